// File: rtl/ecg_pkg.sv
// Shared types and sizing helpers for the ECG moving-window integrator.
package ecg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSquare,
    StAccum,
    StOutput
  } state_e;

  function automatic int unsigned sample_max(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  // Enough headroom for window_len full-scale squared samples.
  function automatic int unsigned sum_width(input int unsigned width, input int unsigned len);
    return (width - 1) + $clog2(len);
  endfunction

endpackage

// File: rtl/ecg_moving_window_integrator_axis_if.sv
// AXI-stream style sample bus (valid/ready/data) used on both sides of the integrator.
interface ecg_moving_window_integrator_axis_if #(
  parameter int unsigned Width = 16
) ();

  logic             tvalid;
  logic             tready;
  logic [Width-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/ecg_moving_window_integrator_axis_ring_buffer.sv
// Sliding-window sample store: returns the sample about to be evicted and writes the new one.
module mwi_ring_buffer #(
  parameter int unsigned Depth = 75,
  parameter int unsigned Width = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [Width-1:0] i_wr_data,
  output logic [Width-1:0] o_old_data,
  output logic             o_full
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [CntW-1:0]  r_fill_cnt;

  assign o_full     = (r_fill_cnt == CntW'(Depth));
  // Until the window is full nothing is evicted.
  assign o_old_data = o_full ? r_mem[r_wr_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
    end else if (i_wr_en) begin
      r_wr_ptr <= (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + PtrW'(1);
      if (!o_full) begin
        r_fill_cnt <= r_fill_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/ecg_moving_window_integrator_axis.sv
// Squares each band-passed sample and emits the scaled sum over a sliding window.
module ecg_moving_window_integrator_axis
  import ecg_pkg::*;
#(
  parameter int unsigned InoutWidth = 16,
  parameter int unsigned WindowLen  = 75,
  parameter int unsigned SqShift    = 15,
  parameter int unsigned OutShift   = 6
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  ecg_moving_window_integrator_axis_if.slave       s_axis,
  ecg_moving_window_integrator_axis_if.master      m_axis,
  output logic                                     overrun
);

  localparam int unsigned SampleW = InoutWidth - 1;
  localparam int unsigned SumW    = sum_width(InoutWidth, WindowLen);
  localparam int unsigned SqW     = 2 * InoutWidth;
  localparam logic [SampleW-1:0] SatMax = SampleW'(sample_max(InoutWidth));

  state_e                r_state;
  logic [InoutWidth-1:0] r_x;
  logic [SampleW-1:0]    r_sq;
  logic [SumW-1:0]       r_sum;
  logic                  r_s_tready;
  logic                  r_m_tvalid;
  logic [InoutWidth-1:0] r_m_tdata;
  logic                  r_overrun;

  logic [InoutWidth-1:0] w_mag;
  logic [SqW-1:0]        w_square;
  logic [SqW-1:0]        w_sq_full;
  logic [SampleW-1:0]    w_sq_sat;
  logic [SumW-1:0]       w_sum_shift;
  logic [SampleW-1:0]    w_out_sample;
  logic [SampleW-1:0]    w_old;
  logic                  w_full;
  logic                  w_wr_en;

  // Unsigned magnitude: -2^(W-1) maps cleanly to 2^(W-1).
  assign w_mag       = r_x[InoutWidth-1] ? (~r_x + InoutWidth'(1)) : r_x;
  assign w_square    = SqW'(w_mag) * SqW'(w_mag);
  assign w_sq_full   = w_square >> SqShift;
  assign w_sum_shift = r_sum >> OutShift;

  always_comb begin
    w_sq_sat     = (w_sq_full > SqW'(SatMax)) ? SatMax : w_sq_full[SampleW-1:0];
    w_out_sample = (64'(w_sum_shift) > 64'(SatMax)) ? SatMax : w_sum_shift[SampleW-1:0];
  end

  assign w_wr_en = (r_state == StAccum);

  mwi_ring_buffer #(
    .Depth (WindowLen),
    .Width (SampleW)
  ) u_ring_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (w_wr_en),
    .i_wr_data  (r_sq),
    .o_old_data (w_old),
    .o_full     (w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_x        <= '0;
      r_sq       <= '0;
      r_sum      <= '0;
      r_s_tready <= 1'b1;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (s_axis.tvalid && !r_s_tready) begin
        r_overrun <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (s_axis.tvalid) begin
            r_x        <= s_axis.tdata;
            r_s_tready <= 1'b0;
            r_state    <= StSquare;
          end
        end
        StSquare: begin
          r_sq    <= w_sq_sat;
          r_state <= StAccum;
        end
        StAccum: begin
          r_sum   <= r_sum + SumW'(r_sq) - SumW'(w_old);
          r_state <= StOutput;
        end
        StOutput: begin
          // First cycle loads the output; it is then held until the handshake.
          if (!r_m_tvalid) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= {1'b0, w_out_sample};
          end else if (m_axis.tready) begin
            r_m_tvalid <= 1'b0;
            r_s_tready <= 1'b1;
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign s_axis.tready = r_s_tready;
  assign m_axis.tvalid = r_m_tvalid;
  assign m_axis.tdata  = r_m_tdata;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_ecg_moving_window_integrator_axis.sv
// Randomized and directed bench for the moving-window integrator against a window-sum model.
module tb_ecg_moving_window_integrator_axis;

  localparam int unsigned W = 16;
  localparam int unsigned L = 75;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic overrun;

  always #10 clk = ~clk;

  ecg_moving_window_integrator_axis_if #(.Width(W)) s_if ();
  ecg_moving_window_integrator_axis_if #(.Width(W)) m_if ();

  ecg_moving_window_integrator_axis #(
    .InoutWidth (W),
    .WindowLen  (L),
    .SqShift    (15),
    .OutShift   (6)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_axis  (s_if.slave),
    .m_axis  (m_if.master),
    .overrun (overrun)
  );

  int n_vec = 0;
  int n_err = 0;
  int q_sq[$];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: output = min((sum of the last L squared samples) >> 6, 32767).
  function automatic int model_push(input int x);
    longint mag;
    longint sq;
    longint s;
    mag = (x < 0) ? -x : x;
    sq  = (mag * mag) >> 15;
    if (sq > 32767) sq = 32767;
    q_sq.push_back(int'(sq));
    if (q_sq.size() > L) void'(q_sq.pop_front());
    s = 0;
    foreach (q_sq[i]) s += q_sq[i];
    s = s >> 6;
    return (s > 32767) ? 32767 : int'(s);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    m_if.tready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_s_tready", s_if.tready, 1);
    check_eq("rst_m_tvalid", m_if.tvalid, 0);
    check_eq("rst_m_tdata", m_if.tdata, 0);
    check_eq("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    q_sq.delete();
  endtask

  // Sends one sample, optionally stalls the output, and returns the output word.
  task automatic feed(input int x, input int stall, output int got);
    int t;
    logic [W-1:0] held;
    @(negedge clk);
    t = 0;
    while (!s_if.tready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!s_if.tready) check_eq("s_tready_timeout", s_if.tready, 1);
    m_if.tready = (stall == 0);
    s_if.tvalid = 1'b1;
    s_if.tdata = W'(x);
    @(negedge clk);
    s_if.tvalid = 1'b0;
    t = 0;
    while (!m_if.tvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!m_if.tvalid) check_eq("m_tvalid_timeout", m_if.tvalid, 1);
    got = int'(m_if.tdata);
    held = m_if.tdata;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_tvalid", m_if.tvalid, 1);
      check_eq("stall_tdata", m_if.tdata, held);
    end
    m_if.tready = 1'b1;
    @(negedge clk);
    check_eq("m_tvalid_drop", m_if.tvalid, 0);
  endtask

  initial begin
    int got;
    int exp;
    int x;
    int stall;
    logic [W-1:0] held;

    do_reset();

    // Latency: valid exactly 3 clk after the accept edge, for 1 clk.
    @(negedge clk);
    s_if.tvalid = 1'b1;
    s_if.tdata = 16'd1024;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    check_eq("lat_s_tready_busy", s_if.tready, 0);
    check_eq("lat_n0", m_if.tvalid, 0);
    @(negedge clk);
    check_eq("lat_n1", m_if.tvalid, 0);
    @(negedge clk);
    check_eq("lat_n2", m_if.tvalid, 0);
    @(negedge clk);
    check_eq("lat_n3", m_if.tvalid, 1);
    check_eq("lat_data", m_if.tdata, model_push(1024));
    @(negedge clk);
    check_eq("lat_n4", m_if.tvalid, 0);
    check_eq("lat_s_tready_back", s_if.tready, 1);

    // Impulse
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      x = (k == 1) ? 32767 : 0;
      feed(x, 0, got);
      check_eq("impulse", got, model_push(x));
      if (k == 1) check_eq("impulse_first", got, 511);
      if (k == 76) check_eq("impulse_evicted", got, 0);
    end
    check_eq("impulse_overrun", overrun, 0);

    // Step
    do_reset();
    for (int k = 1; k <= 90; k++) begin
      feed(1024, 0, got);
      check_eq("step", got, model_push(1024));
      if (k == 75) check_eq("step_k75", got, 37);
    end

    // Saturation
    do_reset();
    for (int k = 1; k <= 80; k++) begin
      feed(-32768, 0, got);
      check_eq("sat", got, model_push(-32768));
      if (k == 65) check_eq("sat_k65", got, 32767);
    end

    // Randomized amplitudes and output stalls
    do_reset();
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 3))
        0: x = int'($urandom_range(0, 65535)) - 32768;
        1: x = int'($urandom_range(0, 4000)) - 2000;
        2: x = int'($urandom_range(0, 400)) - 200;
        default: x = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
      endcase
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      feed(x, stall, got);
      check_eq("random", got, model_push(x));
    end
    check_eq("random_overrun", overrun, 0);

    // Backpressure with a dropped beat
    @(negedge clk);
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata = 16'd5000;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    for (int t = 0; t < 20 && !m_if.tvalid; t++) @(negedge clk);
    exp = model_push(5000);
    check_eq("bp_tvalid", m_if.tvalid, 1);
    check_eq("bp_tdata", m_if.tdata, exp);
    held = m_if.tdata;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      s_if.tvalid = (i == 50);
      s_if.tdata = 16'h7fff;
      check_eq("bp_hold_tvalid", m_if.tvalid, 1);
      check_eq("bp_hold_tdata", m_if.tdata, held);
      check_eq("bp_s_tready", s_if.tready, 0);
    end
    s_if.tvalid = 1'b0;
    check_eq("bp_overrun", overrun, 1);
    m_if.tready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_tvalid", m_if.tvalid, 0);
    check_eq("bp_release_s_tready", s_if.tready, 1);
    @(negedge clk);
    check_eq("bp_single_beat", m_if.tvalid, 0);
    feed(3000, 0, got);
    check_eq("bp_after_drop", got, model_push(3000));

    // Reset mid-stream during ACCUM
    do_reset();
    for (int k = 0; k < 40; k++) begin
      feed(1024, 0, got);
      check_eq("mid_pre", got, model_push(1024));
    end
    @(negedge clk);
    s_if.tvalid = 1'b1;
    s_if.tdata = 16'd1024;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_m_tvalid", m_if.tvalid, 0);
    check_eq("mid_rst_m_tdata", m_if.tdata, 0);
    check_eq("mid_rst_s_tready", s_if.tready, 1);
    check_eq("mid_rst_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q_sq.delete();
    feed(1024, 0, got);
    check_eq("mid_first", got, 0);
    void'(model_push(1024));
    feed(1024, 0, got);
    check_eq("mid_second", got, model_push(1024));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
